// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_8bit datapath leaf:
//   alu_op_e          3-bit opcode encoding, formed from {s2,s1,s0}
//   CMP_GT/LT/EQ      result codes that the unsigned compare places on z
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_SHR = 3'd2,
    OP_SHL = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_CMP = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  localparam logic [7:0] CMP_GT = 8'h01;
  localparam logic [7:0] CMP_LT = 8'h02;
  localparam logic [7:0] CMP_EQ = 8'h00;

endpackage : alu_pkg

// File: rtl/alu_8bit_core.sv
// -----------------------------------------------------------------------------
// alu_8bit_core
// Purely combinational function unit. It computes the next ALU result for the
// registered wrapper. All arithmetic is unsigned and truncated to WIDTH bits.
//
// Optional feature: when the macro ALU_FLAGS_EN is defined, the unit also
// produces the next carry/borrow flag and the next zero flag.
//
// Ports:
//   x_i     [WIDTH-1:0]  operand A
//   y_i     [WIDTH-1:0]  operand B
//   op_i    alu_op_e     operation select
//   z_o     [WIDTH-1:0]  next result
//   cout_o  (ALU_FLAGS_EN) ADD carry-out, SUB borrow (x < y), else 0
//   zero_o  (ALU_FLAGS_EN) 1 when z_o is all zeros
// -----------------------------------------------------------------------------
module alu_8bit_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] z_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             cout_o,
  output logic             zero_o
`endif
);

  // One extra bit keeps the adder carry-out visible for the flag output.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH-1:0] diff;
  logic           borrow;
  logic           carry;

  assign sum_ext = {1'b0, x_i} + {1'b0, y_i};
  assign diff    = x_i - y_i;
  assign borrow  = (x_i < y_i);

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a value unassigned and infer a latch.
    z_o   = '0;
    carry = 1'b0;
    case (op_i)
      OP_AND: z_o = x_i & y_i;
      OP_OR:  z_o = x_i | y_i;
      OP_SHR: z_o = x_i >> 1;
      OP_SHL: z_o = x_i << 1;
      OP_ADD: begin
        z_o   = sum_ext[WIDTH-1:0];
        carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        z_o   = diff;
        carry = borrow;
      end
      OP_CMP: begin
        if (x_i > y_i)      z_o = WIDTH'(CMP_GT);
        else if (x_i < y_i) z_o = WIDTH'(CMP_LT);
        else                z_o = WIDTH'(CMP_EQ);
      end
      OP_XOR: z_o = x_i ^ y_i;
      default: z_o = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign cout_o = carry;
  assign zero_o = (z_o == '0);
`else
  // Carry is only consumed by the flag outputs.
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule : alu_8bit_core

// File: rtl/alu_8bit.sv
// -----------------------------------------------------------------------------
// alu_8bit
// Registered 8-bit ALU. The opcode {s2,s1,s0} picks one of eight functions of
// x and y. The result is loaded into z on every rising edge, so z always shows
// the inputs that were sampled one edge earlier. Reset is synchronous and
// active-high, and it clears z.
//
// Optional feature: define ALU_FLAGS_EN to add the registered flags cout and
// zero. They are loaded together with z and also clear on reset.
//
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous reset, active high
//   x     in   WIDTH  operand A
//   y     in   WIDTH  operand B
//   s2    in   1      opcode bit 2 (MSB)
//   s1    in   1      opcode bit 1
//   s0    in   1      opcode bit 0 (LSB)
//   z     out  WIDTH  registered result
//   cout  out  1      (ALU_FLAGS_EN) registered carry/borrow
//   zero  out  1      (ALU_FLAGS_EN) registered zero-result flag
// -----------------------------------------------------------------------------
module alu_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] z
`ifdef ALU_FLAGS_EN
  ,
  output logic             cout,
  output logic             zero
`endif
);

  alu_op_e          op;
  logic [WIDTH-1:0] z_d, z_q;

  assign op = alu_op_e'({s2, s1, s0});

`ifdef ALU_FLAGS_EN
  logic cout_d, cout_q;
  logic zero_d, zero_q;
`endif

  alu_8bit_core #(.WIDTH(WIDTH)) u_core (
    .x_i    (x),
    .y_i    (y),
    .op_i   (op),
    .z_o    (z_d)
`ifdef ALU_FLAGS_EN
    ,
    .cout_o (cout_d),
    .zero_o (zero_d)
`endif
  );

  // NOTE: the reset here is synchronous because it is sampled only inside the
  // clocked block. The sensitivity list therefore contains clk alone.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its value from before the edge.
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  assign cout = cout_q;
  assign zero = zero_q;
`endif

endmodule : alu_8bit

// File: tb/tb_alu_8bit.sv
// -----------------------------------------------------------------------------
// tb_alu_8bit
// Self-checking bench for alu_8bit. Each driven cycle pushes its expected
// result into a queue. After the next rising edge that entry is popped and
// compared against the DUT outputs. Define ALU_FLAGS_EN to exercise the flag
// outputs as well.
// -----------------------------------------------------------------------------
module tb_alu_8bit;

  typedef struct {
    string      tag;
    logic [7:0] z;
    logic       c;
    logic       zf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, y;
  logic       s2, s1, s0;
  logic [7:0] z;
`ifdef ALU_FLAGS_EN
  logic       cout, zero;
`endif

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .s2   (s2),
    .s1   (s1),
    .s0   (s0),
    .z    (z)
`ifdef ALU_FLAGS_EN
    ,
    .cout (cout),
    .zero (zero)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Independent reference model, written from the opcode table.
  function automatic exp_t model(input string tag, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] op);
    exp_t r;
    int   ai, bi, t;
    ai = int'(a);
    bi = int'(b);
    r.tag = tag;
    r.c   = 1'b0;
    case (op)
      3'd0: t = ai & bi;
      3'd1: t = ai | bi;
      3'd2: t = ai / 2;
      3'd3: t = (ai * 2) % 256;
      3'd4: begin t = (ai + bi) % 256; r.c = (ai + bi) > 255; end
      3'd5: begin t = (ai - bi + 256) % 256; r.c = ai < bi; end
      3'd6: t = (ai > bi) ? 1 : ((ai < bi) ? 2 : 0);
      default: t = ai ^ bi;
    endcase
    r.z  = t[7:0];
    r.zf = (t == 0);
    return r;
  endfunction

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_z, input logic exp_c, input logic exp_zf);
    exp_t e;
    rst = r;
    x   = a;
    y   = b;
    {s2, s1, s0} = op;
    e.tag = tag;
    e.z   = exp_z;
    e.c   = exp_c;
    e.zf  = exp_zf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, z, e.z);
`ifdef ALU_FLAGS_EN
    check({e.tag, ".cout"}, {7'b0, cout}, {7'b0, e.c});
    check({e.tag, ".zero"}, {7'b0, zero}, {7'b0, e.zf});
`endif
  endtask

  task automatic step_model(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op);
    exp_t m;
    m = model(tag, a, b, op);
    step(tag, 1'b0, a, b, op, m.z, m.c, m.zf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: held for two edges with live inputs, then released.
    step("rst0",     1'b1, 8'hFF, 8'hFF, 3'b001, 8'h00, 1'b0, 1'b0);
    step("rst1",     1'b1, 8'hFF, 8'hFF, 3'b001, 8'h00, 1'b0, 1'b0);
    step("rst_rel",  1'b0, 8'hFF, 8'hFF, 3'b001, 8'hFF, 1'b0, 1'b0);

    // Logic and shift operations.
    step("and",      1'b0, 8'hAA, 8'hCC, 3'b000, 8'h88, 1'b0, 1'b0);
    step("or",       1'b0, 8'hAA, 8'hCC, 3'b001, 8'hEE, 1'b0, 1'b0);
    step("shr",      1'b0, 8'hAA, 8'hCC, 3'b010, 8'h55, 1'b0, 1'b0);
    step("shl",      1'b0, 8'hAA, 8'hCC, 3'b011, 8'h54, 1'b0, 1'b0);
    step("xor",      1'b0, 8'hAA, 8'hCC, 3'b111, 8'h66, 1'b0, 1'b0);

    // Arithmetic with wrap.
    step("add_wrap", 1'b0, 8'hAA, 8'hCC, 3'b100, 8'h76, 1'b1, 1'b0);
    step("sub_wrap", 1'b0, 8'hAA, 8'hCC, 3'b101, 8'hDE, 1'b1, 1'b0);
    step("sub_zero", 1'b0, 8'h05, 8'h05, 3'b101, 8'h00, 1'b0, 1'b1);

    // Unsigned compare.
    step("cmp_lt",   1'b0, 8'hAA, 8'hCC, 3'b110, 8'h02, 1'b0, 1'b0);
    step("cmp_gt",   1'b0, 8'hCC, 8'hAA, 3'b110, 8'h01, 1'b0, 1'b0);
    step("cmp_eq",   1'b0, 8'h3C, 8'h3C, 3'b110, 8'h00, 1'b0, 1'b1);
    step("cmp_uns",  1'b0, 8'h80, 8'h7F, 3'b110, 8'h01, 1'b0, 1'b0);

    // Back-to-back: a new opcode on every cycle with fixed operands.
    for (int i = 0; i < 8; i++) begin
      step_model($sformatf("b2b_op%0d", i), 8'h3B, 8'hD7, 3'(i));
    end

    // Reset in the middle of an ADD stream.
    step("mid_add0", 1'b0, 8'h10, 8'h20, 3'b100, 8'h30, 1'b0, 1'b0);
    step("mid_rst",  1'b1, 8'h11, 8'h22, 3'b100, 8'h00, 1'b0, 1'b0);
    step("mid_add1", 1'b0, 8'h01, 8'h02, 3'b100, 8'h03, 1'b0, 1'b0);
    step("mid_add2", 1'b0, 8'hFF, 8'h01, 3'b100, 8'h00, 1'b1, 1'b1);

    // Random vectors against the model.
    for (int i = 0; i < 40; i++) begin
      step_model($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_8bit
